register_file: RTL and testbench
================================

# register_file

Register file for the processor datapath: 32 general-purpose registers of 32 bits, one synchronous write port and two independent combinational read ports (A and B). It sits between instruction decode, which supplies source and destination register numbers, and the ALU and writeback stages. Register 0 is hard-wired to zero.

## Interface
- DATA_W, default 32: register width in bits.
- ADDR_W, default 5: register-number width; NUM_REGS = 2**ADDR_W.
- elk, input, 1: sole clock; all state updates on the rising edge.
- nrst, input, 1: reset, asynchronous and active-low.
- wr_en, input, 1: write enable, sampled on the rising edge of elk.
- wr_addr, input, ADDR_W: destination register number.
- wr_data, input, DATA_W: write data.
- rd_addrA, input, ADDR_W: port A register number.
- rd_addrB, input, ADDR_W: port B register number.
- rd_dataA, output, DATA_W: contents of register rd_addrA.
- rd_dataB, output, DATA_W: contents of register rd_addrB.
- Port order in the instantiation: wr_en, wr_addr, wr_data, rd_addrA, rd_addrB, rd_dataA, rd_dataB, elk, nrst.

## Operation
- Storage holds NUM_REGS words of DATA_W bits.
- Write: on a rising edge of elk with nrst high, wr_en = 1 and wr_addr != 0, the word at wr_addr takes the value of wr_data.
- Any write to register 0 is discarded, and register 0 always reads 0.
- wr_en = 0 leaves all words unchanged. wr_addr and wr_data are don't-care when wr_en = 0.
- Read: rd_dataA and rd_dataB are combinational functions of the address and the stored words. Reads never modify state.
- Ports A and B are fully independent. Both may address the same register, and each may address the register being written.
- Without bypass, a port that reads the register being written returns the old value until the edge, then the new value.
- Every address value from 0 to NUM_REGS-1 is legal. There is no out-of-range condition.
- Reset: while nrst is low, all words are cleared to 0 immediately, regardless of the clock. rd_dataA and rd_dataB therefore read 0 for every address.
- Writes are ignored while nrst is low.
- Reset asserted in the middle of operation discards all prior contents.

## Timing
- Read latency is 0 cycles: the output changes within the same cycle as the address or stored value.
- Write latency: the new value is visible on the read ports right after the rising edge that captures it.
- Reset release: the first rising edge with nrst already high can perform a write.
- A write coinciding with the nrst deassertion edge is not guaranteed. Stimulus keeps wr_en = 0 on that edge.
- No handshake and no stall. One write per cycle at most.

## Configuration
- REGFILE_BYPASS_EN, when defined, enables write-to-read forwarding. If wr_en = 1, wr_addr != 0 and rd_addrX == wr_addr, then rd_dataX = wr_data in the same cycle, before the edge.
- Bypass never applies to register 0, which still reads 0.
- Without REGFILE_BYPASS_EN, read ports show stored contents only, as described in Operation.

## Structure
- Shared package regfile_pkg holds:
  - constants DATA_W = 32, ADDR_W = 5, NUM_REGS = 32 and ZERO_REG = 5'd0;
  - typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- One sub-module is natural: regfile_read_port, containing the address decode/mux, the zero-register override and the optional bypass. It is instantiated twice, for ports A and B.
- The storage array and write logic live in register_file.

## Test plan
- Reset check: hold nrst = 0, then sweep rd_addrA from 0 to 31 and rd_addrB from 31 to 0 -> both ports read 32'h0 for every address.
- Basic write: write 32'hDEAD_BEEF to r5 and 32'h1234_5678 to r31, then read r5 on A and r31 on B -> exact values; r6 still reads 0.
- Register 0 protection: write 32'hFFFF_FFFF to r0 -> r0 reads 0 on both ports after the edge, including with the bypass configuration enabled.
- Write enable and same-cycle write/read:
  - with wr_en = 0 and wr_addr = 7, wr_data = 32'hA5A5_A5A5 -> r7 stays 0;
  - then with wr_en = 1 and rd_addrA = 7 -> before the edge, A reads 0 without the bypass macro and 32'hA5A5_A5A5 with it; after the edge, A reads 32'hA5A5_A5A5 in both.
- Async reset mid-operation: fill r1 to r31 with their index, pulse nrst low between clock edges -> all reads return 0 immediately, without waiting for an elk edge.
- Independent ports: set rd_addrA = rd_addrB = 9 with r9 = 32'h0000_0009, then move rd_addrB to 10 -> A stays 9 and B shows r10, with zero latency.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register count and types for the register file
package regfile_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: write port and two read ports of the register file
interface register_file_if;
   import regfile_pkg::*;
   logic      wr_en;
   reg_addr_t wr_addr;
   reg_data_t wr_data;
   reg_addr_t rd_addrA;
   reg_addr_t rd_addrB;
   reg_data_t rd_dataA;
   reg_data_t rd_dataB;
   modport master (
      output wr_en, wr_addr, wr_data, rd_addrA, rd_addrB,
      input  rd_dataA, rd_dataB
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addrA, rd_addrB,
      output rd_dataA, rd_dataB
   );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational read mux with r0 forced to zero; REGFILE_BYPASS_EN adds write forwarding
module regfile_read_port
   import regfile_pkg::*;
(
   input  reg_addr_t rd_addr,
   input  reg_data_t regs [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  reg_data_t wr_data,
`endif
   output reg_data_t rd_data
);
   // select stored word, r0 always reads zero, optional same-cycle forwarding of the pending write
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      rd_data = (rd_addr == ZERO_REG) ? '0 :
                (wr_en && rd_addr == wr_addr) ? wr_data : regs[rd_addr];
`else
      rd_data = (rd_addr == ZERO_REG) ? '0 : regs[rd_addr];
`endif
   end
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 storage, one synchronous write port, two combinational read ports; optional REGFILE_BYPASS_EN
module register_file
   import regfile_pkg::*;
(
   register_file_if.slave bus,
   input logic            elk,
   input logic            nrst
);
   reg_data_t regs_q [NUM_REGS];
   reg_data_t regs_d [NUM_REGS];
   // next storage contents: apply the write unless it targets r0
   always_comb begin
      regs_d = regs_q;
      if (bus.wr_en && bus.wr_addr != ZERO_REG) regs_d[bus.wr_addr] = bus.wr_data;
   end
   // storage flops, cleared immediately whenever nrst is low
   always_ff @(posedge elk or negedge nrst) begin
      if (!nrst) regs_q <= '{default: '0};
      else regs_q <= regs_d;
   end
   regfile_read_port u_port_a (
      .rd_addr (bus.rd_addrA),
      .regs    (regs_q),
`ifdef REGFILE_BYPASS_EN
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
`endif
      .rd_data (bus.rd_dataA)
   );
   regfile_read_port u_port_b (
      .rd_addr (bus.rd_addrB),
      .regs    (regs_q),
`ifdef REGFILE_BYPASS_EN
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
`endif
      .rd_data (bus.rd_dataB)
   );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks of register_file against an array model
module tb_register_file;
   logic elk = 1'b0;
   logic nrst;
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] mem [32];
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   register_file_if bus();
   register_file dut (.bus(bus.slave), .elk(elk), .nrst(nrst));
   always #5 elk = ~elk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] expect_rd(input logic [4:0] a);
      if (!nrst || a == 0) return 32'h0;
      if (BYP && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
      return mem[a];
   endfunction
   task automatic check_ports(input string tag);
      check({tag, "_A"}, bus.rd_dataA, expect_rd(bus.rd_addrA));
      check({tag, "_B"}, bus.rd_dataB, expect_rd(bus.rd_addrB));
   endtask
   task automatic drive(input logic en, input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
      bus.wr_en = en;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_addrA = ra;
      bus.rd_addrB = rb;
      #1;
   endtask
   task automatic step();
      @(posedge elk);
      if (nrst && bus.wr_en && bus.wr_addr != 0) mem[bus.wr_addr] = bus.wr_data;
      #1;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      nrst = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #1 nrst = 1'b0;
      drive(1'b1, 5'd5, 32'h1111_2222, 5'd5, 5'd5);
      step();
      step();
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd5, 32'h0, 5'(i), 5'(31 - i));
         check("rst_sweep_A", bus.rd_dataA, 32'h0);
         check("rst_sweep_B", bus.rd_dataB, 32'h0);
      end
      @(negedge elk);
      nrst = 1'b1;
      step();
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd0);
      step();
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
      check("basic_r5", bus.rd_dataA, 32'hDEAD_BEEF);
      check("basic_r31", bus.rd_dataB, 32'h1234_5678);
      drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd31);
      check("basic_r6", bus.rd_dataA, 32'h0);
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      check("r0_pre_A", bus.rd_dataA, 32'h0);
      check("r0_pre_B", bus.rd_dataB, 32'h0);
      step();
      check("r0_post_A", bus.rd_dataA, 32'h0);
      check("r0_post_B", bus.rd_dataB, 32'h0);
      drive(1'b0, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
      step();
      check("wren0_r7", bus.rd_dataA, 32'h0);
      drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd0);
      check("same_cyc_pre", bus.rd_dataA, BYP ? 32'hA5A5_A5A5 : 32'h0);
      step();
      check("same_cyc_post", bus.rd_dataA, 32'hA5A5_A5A5);
      drive(1'b1, 5'd9, 32'h0000_0009, 5'd0, 5'd0);
      step();
      drive(1'b1, 5'd10, 32'h0BAD_F00D, 5'd0, 5'd0);
      step();
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      check("indep_A9", bus.rd_dataA, 32'h0000_0009);
      check("indep_B9", bus.rd_dataB, 32'h0000_0009);
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
      check("indep_A_stay", bus.rd_dataA, 32'h0000_0009);
      check("indep_B10", bus.rd_dataB, 32'h0BAD_F00D);
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
         if (n % 4 == 0) bus.rd_addrB = bus.wr_addr;
         #1;
         check_ports("rand_pre");
         step();
         check_ports("rand_post");
      end
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
         step();
      end
      drive(1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
      check("fill_r17", bus.rd_dataA, 32'd17);
      check("fill_r31", bus.rd_dataB, 32'd31);
      @(negedge elk);
      #2 nrst = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      #1;
      check("mid_rst_A", bus.rd_dataA, 32'h0);
      check("mid_rst_B", bus.rd_dataB, 32'h0);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         check("mid_rst_sweep_A", bus.rd_dataA, 32'h0);
         check("mid_rst_sweep_B", bus.rd_dataB, 32'h0);
      end
      @(negedge elk);
      nrst = 1'b1;
      step();
      drive(1'b1, 5'd3, 32'hCAFE_0003, 5'd3, 5'd4);
      step();
      check("after_rst_r3", bus.rd_dataA, 32'hCAFE_0003);
      check("after_rst_r4", bus.rd_dataB, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
